add_exec_pipe: RTL
==================

Name: add_exec_pipe

Overview:
- Two-stage pipelined add/subtract execution unit wrapped around the existing 32-bit combinational prefix adder `cla_adder1` (ports a, b, s; no carry-in, no carry-out).
- Upstream: accepts tagged operations from the issue/scoreboard logic over a valid/ready handshake.
- Downstream: delivers the registered result, tag and flags to writeback.
- Supplies the subtract path (two's-complement negate) and the carry/overflow flags that the bare adder lacks.

Parameters:
- TAG_W, 5, width of the destination tag carried alongside each operation.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all in-flight operations
- in_valid  in  1  upstream operation valid
- in_ready  out  1  unit can accept an operation this cycle
- in_a  in  32  operand A
- in_b  in  32  operand B
- in_sub  in  1  1 = A-B, 0 = A+B
- in_tag  in  TAG_W  destination tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  32  result
- out_tag  out  TAG_W  tag of result
- out_cout  out  1  carry-out (add) / not-borrow (sub)
- out_ovf  out  1  signed overflow

Behaviour:
- Reset: rst_n low asynchronously clears s1_valid and s2_valid, so out_valid=0 and in_ready=1 after reset. Data registers (sum, tag, flags) reset to 0.
- Input transfer on in_valid & in_ready; output transfer on out_valid & out_ready.
- S1 (operand register), loaded on input transfer:
  - a_q = in_a
  - bneg_q = in_sub ? (~in_b + 1) mod 2^32 : in_b
  - also stores sub_q, b31_q = in_b[31], tag
- Adder: combinational between S1 and S2, with a = a_q, b = bneg_q.
- S2 (result register), loaded when s1_valid & (!s2_valid | out_ready). S2 captures:
  - out_sum = s
  - out_tag = s1 tag
  - out_cout = (a31&bn31) | ((a31^bn31) & ~s31), where bn31 = bneg_q[31]. For sub with in_b=0, out_cout is forced to 1.
  - out_ovf = sub_q ? (a31!=b31_q)&(s31!=a31) : (a31==b31_q)&(s31!=a31)
- Stall/advance rules:
  - in_ready = !s1_valid | (!s2_valid | out_ready).
  - When S1 advances and no new input arrives, s1_valid clears.
  - When S2 is consumed and S1 is empty, s2_valid clears.
- Latency and throughput: 2 cycles from input transfer to out_valid with no stall; full throughput of 1 op/cycle with out_ready held high.
- Backpressure: out_ready low holds out_* stable. S1 holds its operation; in_ready drops once S1 is also full. No operation is lost or duplicated.
- Flush:
  - Clears s1_valid and s2_valid at the next edge; the input transfer in that same cycle is discarded.
  - in_ready stays 1 during flush.
  - flush has priority over every simultaneous transfer.
- Wrap: all arithmetic mod 2^32. 0xFFFFFFFF+1 gives sum 0, cout=1, ovf=0.
- Edge case: SUB with in_b=0x80000000 gives bneg=0x80000000; ovf is still correct because the formula uses b31_q.

Optional Feature:
- Macro ADD_EXEC_STATS_EN.
- When defined:
  - adds outputs stat_ops[31:0] (count of output transfers) and stat_ovf[31:0] (output transfers with out_ovf=1).
  - Both counters saturate at 0xFFFFFFFF, are cleared by rst_n, and are not affected by flush.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package add_exec_pkg holds:
  - constant DATA_W=32
  - typedef op_t {a, b, sub, tag}
  - typedef res_t {sum, tag, cout, ovf}
  - function for signed-overflow evaluation
- One sub-module: add_flags, a combinational block computing cout and ovf from a31, bn31, b31, s31 and sub.
- `cla_adder1` is instantiated unchanged.

Test Plan:
- Reset with in_valid=1: out_valid=0 and in_ready=1 while rst_n low; first result appears 2 cycles after release+transfer.
- ADD 0x7FFFFFFF+1, tag 3 → sum 0x80000000, ovf=1, cout=0, tag 3 at cycle +2.
- SUB 5-7 then SUB 0-0x80000000 back-to-back → 0xFFFFFFFE (cout=0, ovf=0), then 0x80000000 (ovf=1), one cycle apart.
- Stream 8 ops with out_ready low for cycles 3-6 → in_ready=0 after 2 accepted. All 8 results arrive in order, unduplicated, and out_* stay stable while stalled.
- Flush with S1 and S2 full plus an incoming op → out_valid=0 the next cycle; no stale result ever emerges.
- ADD_EXEC_STATS_EN: 10 ops, 3 overflowing → stat_ops=10, stat_ovf=3. Counters preloaded near saturation stick at 0xFFFFFFFF.

Source files
------------

// File: rtl/add_exec_pkg.sv
// Shared types and helpers for the add/subtract execution pipe.
// Tag fields are sized for the widest supported TAG_W; the top truncates to its own TAG_W.
package add_exec_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned TAG_MAX_W = 16;

    typedef struct packed {
        logic [DATA_W-1:0]    a;
        logic [DATA_W-1:0]    b;
        logic                 sub;
        logic [TAG_MAX_W-1:0] tag;
    } op_t;

    typedef struct packed {
        logic [DATA_W-1:0]    sum;
        logic [TAG_MAX_W-1:0] tag;
        logic                 cout;
        logic                 ovf;
    } res_t;

    // Uses the original b sign, so negating 0x80000000 still yields the right answer
    function automatic logic signed_ovf(input logic sub, input logic a31,
                                        input logic b31, input logic s31);
        return sub ? ((a31 != b31) && (s31 != a31))
                   : ((a31 == b31) && (s31 != a31));
    endfunction

endpackage

// File: rtl/add_flags.sv
// Carry/not-borrow and signed-overflow flags derived from operand and sum sign bits.
module add_flags
    import add_exec_pkg::*;
(
    input  logic i_a31,
    input  logic i_bn31,
    input  logic i_b31,
    input  logic i_s31,
    input  logic i_sub,
    input  logic i_bzero,
    output logic o_cout,
    output logic o_ovf
);

    always_comb begin
        o_cout = (i_a31 & i_bn31) | ((i_a31 ^ i_bn31) & ~i_s31);
        // Negating zero drops the carry out of ~b+1, so A-0 never borrows
        if (i_sub && i_bzero) begin
            o_cout = 1'b1;
        end
        o_ovf = signed_ovf(i_sub, i_a31, i_b31, i_s31);
    end

endmodule

// File: rtl/cla_adder1.sv
// 32-bit Kogge-Stone prefix adder: no carry-in, no carry-out.
module cla_adder1 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] s
);

    logic [31:0] w_g;
    logic [31:0] w_p;

    // In-place prefix levels; descending i keeps lower bits at their previous level value
    always_comb begin
        w_g = a & b;
        w_p = a ^ b;
        for (int unsigned d = 1; d < 32; d = d * 2) begin
            for (int unsigned i = 31; i >= d; i--) begin
                w_g[i] = w_g[i] | (w_p[i] & w_g[i - d]);
                w_p[i] = w_p[i] & w_p[i - d];
            end
        end
        s = a ^ b ^ {w_g[30:0], 1'b0};
    end

endmodule

// File: rtl/add_exec_pipe.sv
// Two-stage add/subtract execution pipe around cla_adder1 with valid/ready on both sides.
// Optional transfer statistics outputs are enabled by defining ADD_EXEC_STATS_EN.
module add_exec_pipe
    import add_exec_pkg::*;
#(
    parameter int unsigned TAG_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_sub,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_cout,
    output logic              out_ovf
`ifdef ADD_EXEC_STATS_EN
    ,
    output logic [31:0]       stat_ops,
    output logic [31:0]       stat_ovf
`endif
);

    op_t               r_op;
    logic              r_b31;
    logic              r_bzero;
    logic              r_s1_valid;
    res_t              r_res;
    logic              r_s2_valid;

    logic [DATA_W-1:0] w_sum;
    logic              w_cout;
    logic              w_ovf;
    logic              w_in_xfer;
    logic              w_s2_load;

    assign in_ready  = flush | ~r_s1_valid | ~r_s2_valid | out_ready;
    assign w_in_xfer = in_valid & in_ready;
    assign w_s2_load = r_s1_valid & (~r_s2_valid | out_ready);

    cla_adder1 u_adder (
        .a (r_op.a),
        .b (r_op.b),
        .s (w_sum)
    );

    add_flags u_flags (
        .i_a31   (r_op.a[DATA_W-1]),
        .i_bn31  (r_op.b[DATA_W-1]),
        .i_b31   (r_b31),
        .i_s31   (w_sum[DATA_W-1]),
        .i_sub   (r_op.sub),
        .i_bzero (r_bzero),
        .o_cout  (w_cout),
        .o_ovf   (w_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_op       <= '0;
            r_b31      <= 1'b0;
            r_bzero    <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_in_xfer) begin
            r_s1_valid <= 1'b1;
            r_op       <= '{a:   in_a,
                            b:   in_sub ? (~in_b + DATA_W'(1)) : in_b,
                            sub: in_sub,
                            tag: TAG_MAX_W'(in_tag)};
            r_b31      <= in_b[DATA_W-1];
            r_bzero    <= (in_b == '0);
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_res      <= '0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_res      <= '{sum: w_sum, tag: r_op.tag, cout: w_cout, ovf: w_ovf};
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_sum   = r_res.sum;
    assign out_tag   = TAG_W'(r_res.tag);
    assign out_cout  = r_res.cout;
    assign out_ovf   = r_res.ovf;

`ifdef ADD_EXEC_STATS_EN
    logic        w_out_xfer;
    logic [31:0] r_stat_ops;
    logic [31:0] r_stat_ovf;

    assign w_out_xfer = r_s2_valid & out_ready;

    // Counters observe real output transfers only and ignore flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_ops <= '0;
            r_stat_ovf <= '0;
        end else if (w_out_xfer) begin
            if (r_stat_ops != '1) begin
                r_stat_ops <= r_stat_ops + 32'd1;
            end
            if (r_res.ovf && (r_stat_ovf != '1)) begin
                r_stat_ovf <= r_stat_ovf + 32'd1;
            end
        end
    end

    assign stat_ops = r_stat_ops;
    assign stat_ovf = r_stat_ovf;
`endif

endmodule
